// File: rtl/branch_sequencer.sv
// branch_sequencer: four-state fetch/decode/wait/update sequencer that
// advances a 64-bit PC by 4 or by a sign-extended branch offset.
// Handles B (imm26), CBZ and B.LT (imm19). Condition flags for CBZ/B.LT
// are sampled from the datapath once flags_valid is seen.
// Optional: define BRANCH_SEQUENCER_COUNT_EN to add a 32-bit taken_count
// output that counts taken branches.
module branch_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        flags_valid,
    input  logic        zero,
    input  logic        negative,
    input  logic        overflow,
    output logic [63:0] PC,
    output logic        BrTaken,
    output logic        UncondBr,
`ifdef BRANCH_SEQUENCER_COUNT_EN
    output logic [31:0] taken_count,
`endif
    output logic        busy
);

    typedef enum logic [1:0] {
        FETCH,
        DECODE,
        WAIT_FLAGS,
        UPDATE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] instr_q;
    logic        zero_q;
    logic        neg_q;
    logic        ovf_q;
    logic        load_instr;
    logic        load_flags;
    logic        is_b;
    logic        is_cbz;
    logic        is_blt;
    logic        taken;
    logic [63:0] offset;

    // Classify the held word and form the branch decision and offset.
    // Flags are only consulted for CBZ/B.LT, which always pass through
    // WAIT_FLAGS, so the flag register is always fresh when it matters.
    always_comb begin
        is_b   = (instr_q[31:26] == 6'b000101);
        is_cbz = (instr_q[31:24] == 8'b10110100);
        is_blt = (instr_q[31:24] == 8'b01010100) && (instr_q[4:0] == 5'b01011);
        taken  = is_b || (is_cbz && zero_q) || (is_blt && (neg_q != ovf_q));
        if (is_b) begin
            offset = {{36{instr_q[25]}}, instr_q[25:0], 2'b00};
        end else begin
            offset = {{43{instr_q[23]}}, instr_q[23:5], 2'b00};
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and per-state outputs.
    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        busy        = 1'b1;
        BrTaken     = 1'b0;
        UncondBr    = 1'b0;
        load_instr  = 1'b0;
        load_flags  = 1'b0;
        case (state)
            FETCH: begin
                instr_ready = 1'b1;
                busy        = 1'b0;
                if (instr_valid) begin
                    load_instr = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                if (is_cbz || is_blt) begin
                    state_next = WAIT_FLAGS;
                end else begin
                    state_next = UPDATE;
                end
            end
            WAIT_FLAGS: begin
                if (flags_valid) begin
                    load_flags = 1'b1;
                    state_next = UPDATE;
                end
            end
            UPDATE: begin
                BrTaken    = taken;
                UncondBr   = is_b;
                state_next = FETCH;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // Held instruction: loaded only on acceptance in FETCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= '0;
        end else if (load_instr) begin
            instr_q <= instruction;
        end
    end

    // Condition flags sampled when the datapath reports them valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (load_flags) begin
            zero_q <= zero;
            neg_q  <= negative;
            ovf_q  <= overflow;
        end
    end

    // Program counter: changes only on the UPDATE edge, wrapping mod 2^64.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC <= '0;
        end else if (state == UPDATE) begin
            PC <= PC + (taken ? offset : 64'd4);
        end
    end

`ifdef BRANCH_SEQUENCER_COUNT_EN
    // Taken-branch counter, wraps at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taken_count <= '0;
        end else if (state == UPDATE && taken) begin
            taken_count <= taken_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
module tb_branch_sequencer;

    logic        clk;
    logic        clk_run;
    logic        rst;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        instr_ready;
    logic        flags_valid;
    logic        zero;
    logic        negative;
    logic        overflow;
    logic [63:0] PC;
    logic        BrTaken;
    logic        UncondBr;
    logic        busy;
`ifdef BRANCH_SEQUENCER_COUNT_EN
    logic [31:0] taken_count;
`endif

    int total;
    int bad;

    branch_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .flags_valid (flags_valid),
        .zero        (zero),
        .negative    (negative),
        .overflow    (overflow),
        .PC          (PC),
        .BrTaken     (BrTaken),
        .UncondBr    (UncondBr),
`ifdef BRANCH_SEQUENCER_COUNT_EN
        .taken_count (taken_count),
`endif
        .busy        (busy)
    );

    // Gated clock so reset can be applied with the clock stopped.
    initial clk = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    // Reference model: next PC from the architectural rules.
    function automatic logic [63:0] model_next(input logic [63:0] pc, input logic [31:0] ins,
                                               input logic z, input logic n, input logic v,
                                               output bit tk, output bit unc, output bit cond);
        longint off;
        longint unsigned f;
        tk = 0; unc = 0; cond = 0; off = 0;
        if ((ins >> 26) == 32'd5) begin
            unc = 1; tk = 1;
            f = 64'(ins & 32'h03FF_FFFF);
            off = longint'(f);
            if (f >= 64'h0200_0000) off = off - 64'h0400_0000;
        end else if ((ins >> 24) == 32'hB4 ||
                     ((ins >> 24) == 32'h54 && (ins & 32'h1F) == 32'd11)) begin
            cond = 1;
            tk = ((ins >> 24) == 32'hB4) ? (z == 1'b1) : (n != v);
            f = 64'((ins >> 5) & 32'h7FFFF);
            off = longint'(f);
            if (f >= 64'h40000) off = off - 64'h80000;
        end
        if (tk) return pc + 64'(off * 4);
        return pc + 64'd4;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs one instruction from FETCH back to FETCH. flags are presented
    // during the wc-th WAIT_FLAGS cycle; other inputs carry noise.
    task automatic exec_instr(input logic [31:0] ins, input int wc,
                              input logic z, input logic n, input logic v,
                              output int edges, output int br_p, output int unc_p,
                              output bit early, output bit tmo);
        logic [63:0] pc0;
        int flag_edge;
        edges = 0; br_p = 0; unc_p = 0; early = 0; tmo = 0;
        pc0 = PC;
        flag_edge = 1 + wc;
        instruction = ins;
        instr_valid = 1'b1;
        flags_valid = 1'b0;
        zero = 1'($urandom_range(0, 1));
        negative = 1'($urandom_range(0, 1));
        overflow = 1'($urandom_range(0, 1));
        while (1) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (BrTaken) br_p++;
            if (UncondBr) unc_p++;
            if (!busy) break;
            if (PC !== pc0) early = 1;
            instruction = $urandom;
            instr_valid = 1'($urandom_range(0, 1));
            if (edges == flag_edge) begin
                flags_valid = 1'b1;
                zero = z; negative = n; overflow = v;
            end else begin
                flags_valid = 1'b0;
                zero = 1'($urandom_range(0, 1));
                negative = 1'($urandom_range(0, 1));
                overflow = 1'($urandom_range(0, 1));
            end
            if (edges >= 60) begin
                tmo = 1;
                break;
            end
        end
        instr_valid = 1'b0;
        flags_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++; if (PC !== 64'h0) begin bad++; $display("FAIL reset_pc: got %h want 0", PC); end
        total++; if (instr_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL reset_ready_busy: got %b%b want 10", instr_ready, busy); end
        total++; if (BrTaken !== 1'b0 || UncondBr !== 1'b0) begin bad++; $display("FAIL reset_pulses: got %b%b want 00", BrTaken, UncondBr); end
        rst = 1'b0;
        instruction = 32'h8B050043; instr_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        instr_valid = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        instr_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        instr_valid = 1'b0;
        total++; if (PC !== 64'h4 || busy !== 1'b1) begin bad++; $display("FAIL pre_reset_state: got pc=%h busy=%b want pc=4 busy=1", PC, busy); end
        clk_run = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++; if (PC !== 64'h0) begin bad++; $display("FAIL async_reset_pc: got %h want 0", PC); end
        total++; if (instr_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL async_reset_ready_busy: got %b%b want 10", instr_ready, busy); end
        #1 rst = 1'b0;
        clk_run = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_nonbranch();
        int e, b, u; bit early, tmo;
        exec_instr(32'h8B050043, 0, 1'b1, 1'b1, 1'b0, e, b, u, early, tmo);
        total++; if (PC !== 64'h4) begin bad++; $display("FAIL nonbranch_pc: got %h want 4", PC); end
        total++; if (e != 3 || tmo) begin bad++; $display("FAIL nonbranch_latency: got %0d want 3", e); end
        total++; if (b != 0 || u != 0) begin bad++; $display("FAIL nonbranch_pulses: got br=%0d unc=%0d want 0 0", b, u); end
        total++; if (early) begin bad++; $display("FAIL nonbranch_pc_stable: got early change want none"); end
    endtask

    task automatic test_b_backward();
        int e, b, u; bit early, tmo;
        for (int i = 0; i < 3; i++) begin
            exec_instr(32'h8B050043, 0, 1'b0, 1'b0, 1'b0, e, b, u, early, tmo);
            total++; if (PC !== 64'(8 + 4 * i)) begin bad++; $display("FAIL b_setup_pc: got %h want %h", PC, 64'(8 + 4 * i)); end
        end
        exec_instr(32'h17FFFFFE, 0, 1'b0, 1'b0, 1'b0, e, b, u, early, tmo);
        total++; if (PC !== 64'h8) begin bad++; $display("FAIL b_backward_pc: got %h want 8", PC); end
        total++; if (e != 3 || tmo) begin bad++; $display("FAIL b_backward_latency: got %0d want 3", e); end
        total++; if (b != 1 || u != 1) begin bad++; $display("FAIL b_backward_pulses: got br=%0d unc=%0d want 1 1", b, u); end
        total++; if (early) begin bad++; $display("FAIL b_pc_stable: got early change want none"); end
    endtask

    task automatic test_cbz();
        int e, b, u; bit early, tmo;
        for (int i = 0; i < 6; i++) begin
            exec_instr(32'h8B050043, 0, 1'b1, 1'b0, 1'b0, e, b, u, early, tmo);
        end
        total++; if (PC !== 64'h20) begin bad++; $display("FAIL cbz_setup_pc: got %h want 20", PC); end
        exec_instr(32'hB4000060, 2, 1'b1, 1'b0, 1'b0, e, b, u, early, tmo);
        total++; if (PC !== 64'h2C) begin bad++; $display("FAIL cbz_taken_pc: got %h want 2c", PC); end
        total++; if (e != 5 || tmo) begin bad++; $display("FAIL cbz_latency: got %0d want 5", e); end
        total++; if (b != 1 || u != 0) begin bad++; $display("FAIL cbz_taken_pulses: got br=%0d unc=%0d want 1 0", b, u); end
        total++; if (early) begin bad++; $display("FAIL cbz_pc_stable: got early change want none"); end
        exec_instr(32'h17FFFFFD, 0, 1'b0, 1'b0, 1'b0, e, b, u, early, tmo);
        total++; if (PC !== 64'h20) begin bad++; $display("FAIL cbz_rewind_pc: got %h want 20", PC); end
        exec_instr(32'hB4000060, 2, 1'b0, 1'b1, 1'b0, e, b, u, early, tmo);
        total++; if (PC !== 64'h24) begin bad++; $display("FAIL cbz_not_taken_pc: got %h want 24", PC); end
        total++; if (b != 0 || e != 5) begin bad++; $display("FAIL cbz_not_taken_pulse: got br=%0d edges=%0d want 0 5", b, e); end
    endtask

    task automatic test_blt_wrap();
        int e, b, u; bit early, tmo;
        apply_reset();
        exec_instr(32'h54FFFFEB, 1, 1'b0, 1'b1, 1'b0, e, b, u, early, tmo);
        total++; if (PC !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL blt_taken_pc: got %h want fffffffffffffffc", PC); end
        total++; if (b != 1 || u != 0 || e != 4) begin bad++; $display("FAIL blt_taken_pulses: got br=%0d unc=%0d edges=%0d want 1 0 4", b, u, e); end
        exec_instr(32'h8B050043, 0, 1'b0, 1'b0, 1'b0, e, b, u, early, tmo);
        total++; if (PC !== 64'h0) begin bad++; $display("FAIL wrap_pc: got %h want 0", PC); end
        exec_instr(32'h54FFFFEB, 1, 1'b0, 1'b1, 1'b1, e, b, u, early, tmo);
        total++; if (PC !== 64'h4) begin bad++; $display("FAIL blt_not_taken_pc: got %h want 4", PC); end
        total++; if (b != 0) begin bad++; $display("FAIL blt_not_taken_pulse: got br=%0d want 0", b); end
    endtask

    task automatic test_reset_wait_flags();
        int br_seen;
        br_seen = 0;
        instruction = 32'hB4000060; instr_valid = 1'b1; flags_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        instr_valid = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        total++; if (busy !== 1'b1 || PC !== 64'h4) begin bad++; $display("FAIL wait_flags_hold: got busy=%b pc=%h want 1 4", busy, PC); end
        #2 rst = 1'b1;
        #1;
        total++; if (PC !== 64'h0 || busy !== 1'b0 || instr_ready !== 1'b1) begin bad++; $display("FAIL wait_reset_state: got pc=%h busy=%b ready=%b want 0 0 1", PC, busy, instr_ready); end
        @(negedge clk);
        rst = 1'b0;
        flags_valid = 1'b1; zero = 1'b1;
        repeat (4) begin
            @(posedge clk); @(negedge clk);
            if (BrTaken) br_seen++;
        end
        flags_valid = 1'b0;
        total++; if (PC !== 64'h0 || busy !== 1'b0 || br_seen != 0) begin bad++; $display("FAIL late_flags_ignored: got pc=%h busy=%b br=%0d want 0 0 0", PC, busy, br_seen); end
`ifdef BRANCH_SEQUENCER_COUNT_EN
        total++; if (taken_count !== 32'h0) begin bad++; $display("FAIL count_after_reset: got %0d want 0", taken_count); end
`endif
    endtask

    task automatic test_random();
        int e, b, u; bit early, tmo;
        logic [63:0] mpc;
        logic [31:0] ins;
        logic z, n, v;
        bit tk, unc, cond;
        int wc;
        int mcount;
        mpc = 64'h0;
        mcount = 0;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0: ins = {6'b000101, 26'($urandom)};
                1: ins = {8'hB4, 24'($urandom)};
                2: ins = {8'h54, 19'($urandom), 5'b01011};
                3: ins = {8'h54, 19'($urandom), 5'($urandom_range(0, 10))};
                default: ins = $urandom;
            endcase
            z = 1'($urandom_range(0, 1));
            n = 1'($urandom_range(0, 1));
            v = 1'($urandom_range(0, 1));
            wc = $urandom_range(1, 3);
            mpc = model_next(mpc, ins, z, n, v, tk, unc, cond);
            if (tk) mcount++;
            exec_instr(ins, wc, z, n, v, e, b, u, early, tmo);
            total++; if (PC !== mpc) begin bad++; $display("FAIL rand_pc[%0d]: ins=%h got %h want %h", i, ins, PC, mpc); end
            total++; if (e != (cond ? 3 + wc : 3) || tmo) begin bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, e, cond ? 3 + wc : 3); end
            total++; if (b != int'(tk) || u != int'(unc)) begin bad++; $display("FAIL rand_pulses[%0d]: got br=%0d unc=%0d want %0d %0d", i, b, u, tk, unc); end
            total++; if (early) begin bad++; $display("FAIL rand_pc_stable[%0d]: got early change want none", i); end
`ifdef BRANCH_SEQUENCER_COUNT_EN
            total++; if (taken_count !== 32'(mcount)) begin bad++; $display("FAIL rand_count[%0d]: got %0d want %0d", i, taken_count, mcount); end
`endif
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        clk_run = 1'b1;
        rst = 1'b1;
        instruction = '0;
        instr_valid = 1'b0;
        flags_valid = 1'b0;
        zero = 1'b0;
        negative = 1'b0;
        overflow = 1'b0;
        test_reset();
        test_nonbranch();
        test_b_backward();
        test_cbz();
        test_blt_wrap();
        test_reset_wait_flags();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
